// File: rtl/xnor_acc_pkg.sv
// Shared types and sizing helpers for the XNOR popcount accumulator.
package xnor_acc_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  // Width needed to hold the largest possible frame sum (WIDTH*BEATS).
  function automatic int acc_width(input int width, input int beats);
    return $clog2(width * beats + 1);
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/xnor_popcount.sv
// Combinational count of matching bit positions between two vectors.
module xnor_popcount #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [CW-1:0]    cnt
);

  logic [WIDTH-1:0] match;

  assign match = ~(a ^ b);

  always_comb begin
    cnt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt = cnt + CW'(match[i]);
    end
  end

endmodule

// File: rtl/xnor_popcount_acc.sv
// Frame accumulator of XNOR popcounts over BEATS operand beats.
// Optional XNOR_ACC_THRESH_EN adds a threshold compare (thresh in, out_fire out).
module xnor_popcount_acc
  import xnor_acc_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int BEATS = 4,
  localparam int ACC_W = acc_width(WIDTH, BEATS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_sum,
`ifdef XNOR_ACC_THRESH_EN
  input  logic [ACC_W-1:0] thresh,
  output logic             out_fire,
`endif
  output logic             out_match
);

  localparam int PC_W  = $clog2(WIDTH + 1);
  localparam int CNT_W = cnt_width(BEATS);
  localparam logic [ACC_W-1:0] FULL     = ACC_W'(WIDTH * BEATS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

  state_t           state;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] beat_cnt;
  logic [PC_W-1:0]  pc;
  logic [ACC_W-1:0] acc_next;
  logic             last_beat;

  xnor_popcount #(.WIDTH(WIDTH)) u_popcount (
    .a   (in_a),
    .b   (in_b),
    .cnt (pc)
  );

  assign acc_next  = acc + ACC_W'(pc);
  assign last_beat = (beat_cnt == LAST_CNT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACCUM;
      acc       <= '0;
      beat_cnt  <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_match <= 1'b0;
`ifdef XNOR_ACC_THRESH_EN
      out_fire  <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (clr) begin
            acc      <= '0;
            beat_cnt <= '0;
          end else if (in_valid) begin
            if (last_beat) begin
              out_sum   <= acc_next;
              out_match <= (acc_next == FULL);
`ifdef XNOR_ACC_THRESH_EN
              out_fire  <= (acc_next >= thresh);
`endif
              acc       <= '0;
              beat_cnt  <= '0;
              in_ready  <= 1'b0;
              out_valid <= 1'b1;
              state     <= HOLD;
            end else begin
              acc      <= acc_next;
              beat_cnt <= beat_cnt + 1'b1;
            end
          end
        end
        HOLD: begin
          // clr and a consumer handshake both release the result and restart.
          if (clr || out_ready) begin
            acc       <= '0;
            beat_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            state     <= ACCUM;
          end
        end
        default: begin
          state     <= ACCUM;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
